// File: rtl/periph_interco_pkg.sv
// periph_interco_pkg: shared index-width helper and response-tracker entry type
package periph_interco_pkg;
  localparam int TRK_IDX_W = 8;
  typedef struct packed {
    logic [TRK_IDX_W-1:0] idx;
  } trk_entry_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/periph_id_fifo.sv
// periph_id_fifo: in-order FIFO of master indices awaiting a slave response
module periph_id_fifo
  import periph_interco_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  trk_entry_t push_data,
  output trk_entry_t pop_data,
  output logic       full,
  output logic       empty
);
  localparam int PW = idx_w(DEPTH);
  localparam int CW = idx_w(DEPTH + 1);
  trk_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign pop_data = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
  // pointers wrap explicitly since DEPTH need not be a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/periph_slave_arbiter.sv
// periph_slave_arbiter: round-robin arbiter sharing one peripheral slave port among N_MASTER requesters
module periph_slave_arbiter
  import periph_interco_pkg::*;
#(
  parameter int N_MASTER = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = N_MASTER,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_MASTER-1:0]                 data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]                 data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i,
  input  logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_i,
  output logic [N_MASTER-1:0]                 data_gnt_o,
  output logic [N_MASTER-1:0]                 data_r_valid_o,
  output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
  output logic                                per_req_o,
  output logic [ADDR_WIDTH-1:0]               per_add_o,
  output logic                                per_wen_o,
  output logic [DATA_WIDTH-1:0]               per_wdata_o,
  output logic [BE_WIDTH-1:0]                 per_be_o,
  output logic [ID_WIDTH-1:0]                 per_ID_o,
  input  logic                                per_gnt_i,
  input  logic                                per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]               per_r_rdata_i
);
  localparam int IW = idx_w(N_MASTER);
  logic [IW-1:0] rr_q, sel_q, rr_sel, sel, rr_nxt, head_idx, scan;
  logic lock_q, hs, pop, full, empty;
  trk_entry_t head;
  int j;
  // descending scan so the requester closest after rr_q wins
  always_comb begin
    rr_sel = rr_q;
    j = 0;
    scan = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      scan = IW'(j);
      if (data_req_i[scan]) rr_sel = scan;
    end
  end
  assign sel = lock_q ? sel_q : rr_sel;
  assign per_req_o = data_req_i[sel] & ~full;
  assign hs = per_req_o & per_gnt_i;
  assign pop = per_r_valid_i & ~empty;
  assign rr_nxt = (sel == IW'(N_MASTER - 1)) ? '0 : sel + 1'b1;
  assign head_idx = IW'(head.idx);
  assign per_add_o = data_add_i[sel];
  assign per_wen_o = data_wen_i[sel];
  assign per_wdata_o = data_wdata_i[sel];
  assign per_be_o = data_be_i[sel];
  assign per_ID_o = data_ID_i[sel];
  assign data_r_rdata_o = per_r_rdata_i;
  always_comb begin
    data_gnt_o = '0;
    data_r_valid_o = '0;
    data_gnt_o[sel] = hs;
    data_r_valid_o[head_idx] = pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      lock_q <= 1'b0;
      sel_q <= '0;
    end else if (hs) begin
      rr_q <= rr_nxt;
      lock_q <= 1'b0;
    end else if (per_req_o) begin
      lock_q <= 1'b1;
      sel_q <= sel;
    end
  end
  periph_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(hs),
    .pop(per_r_valid_i),
    .push_data('{idx: TRK_IDX_W'(sel)}),
    .pop_data(head),
    .full(full),
    .empty(empty)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(per_r_valid_i && empty))
    else $warning("spurious response dropped");
endmodule

// File: tb/tb_periph_slave_arbiter.sv
// tb_periph_slave_arbiter: scoreboard bench for the round-robin peripheral slave arbiter
module tb_periph_slave_arbiter;
  localparam int N = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  typedef struct {
    int idx;
    logic [DW-1:0] data;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, wen, gnt_o, rv_o;
  logic [N-1:0][AW-1:0] add;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0][BW-1:0] be;
  logic [N-1:0][N-1:0] id;
  logic [DW-1:0] rdata_o, rdata_i, p_wdata;
  logic p_req, p_wen, gnt_i, rv_i;
  logic [AW-1:0] p_add;
  logic [BW-1:0] p_be;
  logic [N-1:0] p_id;
  int total = 0;
  int bad = 0;
  int exp_gnt[$];
  rsp_t exp_rsp[$];
  always #5 clk = ~clk;
  periph_slave_arbiter #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata),
    .data_be_i(be), .data_ID_i(id),
    .data_gnt_o(gnt_o), .data_r_valid_o(rv_o), .data_r_rdata_o(rdata_o),
    .per_req_o(p_req), .per_add_o(p_add), .per_wen_o(p_wen), .per_wdata_o(p_wdata),
    .per_be_o(p_be), .per_ID_o(p_id),
    .per_gnt_i(gnt_i), .per_r_valid_i(rv_i), .per_r_rdata_i(rdata_i)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input int i, input logic [DW-1:0] d);
    rv_i = 1'b1;
    rdata_i = d;
    exp_rsp.push_back('{i, d});
  endtask
  always @(negedge clk) begin
    if (gnt_o != '0) begin
      if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'(gnt_o), 64'h0);
      else chk("gnt", 64'(gnt_o), 64'(1) << exp_gnt.pop_front());
    end
    if (rv_o != '0) begin
      if (exp_rsp.size() == 0) chk("unexpected_rvalid", 64'(rv_o), 64'h0);
      else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rvalid", 64'(rv_o), 64'(1) << e.idx);
        chk("rdata", 64'(rdata_o), 64'(e.data));
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    req = '0;
    gnt_i = 1'b0;
    rv_i = 1'b0;
    rdata_i = '0;
    for (int i = 0; i < N; i++) begin
      add[i] = 32'h4000_0000 + 32'(i) * 32'h100;
      wen[i] = i[0];
      wdata[i] = 32'hC0DE_0000 + 32'(i);
      be[i] = BW'(i + 1);
      id[i] = N'(1 << i);
    end
    #1;
    chk("rst_req", 64'(p_req), 0);
    chk("rst_gnt", 64'(gnt_o), 0);
    chk("rst_rvalid", 64'(rv_o), 0);
    chk("rst_rr", 64'(dut.rr_q), 0);
    chk("rst_cnt", 64'(dut.u_fifo.count_q), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // rotation: all requesting, slave always granting, responses keep the FIFO from filling
    req = '1;
    gnt_i = 1'b1;
    exp_gnt.push_back(0);
    #1;
    chk("rot_add0", 64'(p_add), 64'h4000_0000);
    chk("rot_id0", 64'(p_id), 64'h1);
    step();
    for (int k = 1; k <= 5; k++) begin
      exp_gnt.push_back(k % N);
      rsp(k - 1, 32'hD000_0000 + 32'(k - 1));
      step();
    end
    rv_i = 1'b0;
    exp_gnt.push_back(1);
    step();
    // full: push attempt and pop in the same cycle, no bypass
    rsp(0, 32'hD000_0005);
    #1;
    chk("full_req", 64'(p_req), 0);
    chk("full_gnt", 64'(gnt_o), 0);
    step();
    rv_i = 1'b0;
    exp_gnt.push_back(2);
    step();
    chk("full_cnt", 64'(dut.u_fifo.count_q), 2);
    chk("full_rr", 64'(dut.rr_q), 3);
    req = '0;
    rsp(1, 32'hD000_0006);
    step();
    rsp(2, 32'hD000_0007);
    step();
    rv_i = 1'b0;
    // lock: master 2 held ungranted, master 0 arrives and must not displace it
    req = 5'b00100;
    gnt_i = 1'b0;
    repeat (3) begin
      #1;
      chk("lock_req", 64'(p_req), 1);
      chk("lock_add", 64'(p_add), 64'h4000_0200);
      step();
    end
    req = 5'b00101;
    #1 chk("lock_hold", 64'(p_add), 64'h4000_0200);
    step();
    gnt_i = 1'b1;
    exp_gnt.push_back(2);
    #1 chk("lock_gnt", 64'(gnt_o), 64'b00100);
    step();
    req = '0;
    chk("lock_rr", 64'(dut.rr_q), 3);
    // response routing
    rsp(2, 32'hD000_0008);
    step();
    rv_i = 1'b0;
    req = 5'b00010;
    exp_gnt.push_back(1);
    step();
    req = 5'b01000;
    exp_gnt.push_back(3);
    step();
    req = '0;
    rsp(1, 32'hA5);
    step();
    rsp(3, 32'h5A);
    step();
    rv_i = 1'b0;
    // wrap from the last index and a spurious response
    chk("wrap_rr0", 64'(dut.rr_q), 4);
    req = 5'b00001;
    exp_gnt.push_back(0);
    step();
    req = '0;
    chk("wrap_rr1", 64'(dut.rr_q), 1);
    rsp(0, 32'hD000_0009);
    step();
    rv_i = 1'b1;
    rdata_i = 32'hDEAD_BEEF;
    #1 chk("spur_rvalid", 64'(rv_o), 0);
    step();
    rv_i = 1'b0;
    chk("spur_cnt", 64'(dut.u_fifo.count_q), 0);
    // async reset with a lock and one outstanding entry
    req = 5'b00010;
    exp_gnt.push_back(1);
    step();
    req = 5'b00100;
    gnt_i = 1'b0;
    step();
    chk("pre_lock", 64'(dut.lock_q), 1);
    rst_n = 1'b0;
    req = '0;
    gnt_i = 1'b1;
    rv_i = 1'b1;
    rdata_i = 32'h1234_5678;
    #1;
    chk("arst_rvalid", 64'(rv_o), 0);
    chk("arst_gnt", 64'(gnt_o), 0);
    chk("arst_req", 64'(p_req), 0);
    chk("arst_rr", 64'(dut.rr_q), 0);
    chk("arst_cnt", 64'(dut.u_fifo.count_q), 0);
    chk("arst_lock", 64'(dut.lock_q), 0);
    step();
    rv_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
    chk("gnt_queue_drained", 64'(exp_gnt.size()), 0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
